core_issue_ctrl: RTL
====================

// Module: core_issue_ctrl
// PURPOSE
//  Backend end of the frontend/backend issue interface. Consumes the frontend's registered two-slot decoded window
//  (inst_valid/inst) and returns the in-order issue vector. Tracks RAW hazards in a per-register scoreboard,
//  latches issued instructions into the execute-stage register, and drives the redirect (rst_jmp) and idle
//  (wait_inst/int_detect) controls back to the frontend.
// PARAMETERS
//  SB_CNT_W   2   width of per-register outstanding-write counter (max outstanding = 2**SB_CNT_W-1)
//  WB_PORTS   2   number of writeback ports that retire scoreboard entries
// PORTS
//  clk                 in   1          clock; all state on posedge
//  rst                 in   1          asynchronous, active-high reset
//  fe_inst_valid_i     in   2          frontend window valid; only 2'b00, 2'b01, 2'b11 are legal
//  fe_inst_i           in   2 x inst_t frontend window (decode_info, reg_info, pc, bpu_predict, fetch_excp)
//  fe_issue_o          out  2          issue vector to frontend; combinational; only 2'b00, 2'b01, 2'b11
//  rst_jmp_o           out  1          frontend flush/redirect pulse (registered)
//  rst_jmp_target_o    out  32         redirect target, valid while rst_jmp_o
//  wait_inst_o         out  1          idle-lock request to frontend
//  int_detect_o        out  1          one-cycle idle-release pulse
//  redirect_valid_i    in   1          backend redirect (mispredict/exception/ertn) from commit stage
//  redirect_target_i   in   32         redirect target
//  int_pending_i       in   1          interrupt pending (from CSR)
//  wb_valid_i          in   WB_PORTS   writeback valid
//  wb_reg_i            in   WB_PORTS x 5  writeback destination register
//  ex_ready_i          in   1          execute stage accepts new instructions
//  ex_valid_o          out  2          execute-stage register valid
//  ex_inst_o           out  2 x inst_t execute-stage register contents
// BEHAVIOUR
//  Reset: fe_issue_o=0, rst_jmp_o=0, rst_jmp_target_o=0, wait_inst_o=0, int_detect_o=0, ex_valid_o=0,
//   all scoreboard counters 0, FSM=RUN.
//  Scoreboard: cnt[r] +1 per issued instruction with w_reg=r; -1 per wb_valid_i port with wb_reg_i=r;
//   increment and decrement in the same cycle net out; r0 is never tracked; reg_info.w_reg=0 means no write.
//  Slot0 issues iff: FSM=RUN, no rst_jmp_o this cycle, no redirect_valid_i, ex_ready_i, fe_inst_valid_i[0],
//   cnt of both nonzero r_reg ==0, cnt[w_reg] not saturated.
//  Slot1 issues iff slot0 issues, fe_inst_valid_i[1], and the same scoreboard checks pass. Slot1 is additionally
//   blocked if: its r_reg or w_reg equals slot0 w_reg (nonzero); issue_class equal and not ALU; either class CSR/IDLE.
//  Same-cycle writeback does not bypass: a source register with cnt=1 and a matching wb this cycle still stalls.
//  Execute register: on issue, ex_valid_o<=fe_issue_o and ex_inst_o<=fe_inst_i (latency 1 cycle).
//   !ex_ready_i holds ex regs and forces fe_issue_o=0.
//  Redirect: redirect_valid_i -> next cycle rst_jmp_o=1, target=redirect_target_i, ex_valid_o=0, all cnt=0.
//   Contract: the backend asserts redirect only when all older in-flight writes have completed.
//   Back-to-back redirects: the later one wins; rst_jmp_o stays high.
//  Idle FSM: RUN -(slot0 issues IDLE)-> IDLE_FLUSH: rst_jmp_o=1, target=pc+4, wait_inst_o=1 -> IDLE_WAIT:
//   wait_inst_o=1, issue=0 until int_pending_i -> IDLE_EXIT: int_detect_o=1, wait_inst_o=0 (1 cycle) -> RUN.
//   int_pending_i already high in IDLE_FLUSH still passes through IDLE_WAIT for one cycle.
//   redirect_valid_i in any idle state -> RUN with a normal redirect; wait_inst_o=0, int_detect_o=1 for one cycle.
// CONFIGURATION
//  CORE_DUAL_ISSUE_EN defined: dual issue per the rules above.
//  Undefined: fe_issue_o[1] tied 0 and ex_valid_o[1] always 0 (single issue); scoreboard and FSM unchanged.
// STRUCTURE
//  Shared package: issue_class_t enum (ALU, MEM, BR, MUL, CSR, IDLE), issue_class(is_t) function, idle_fsm_t enum.
//  inst_t, is_t and reg_info_t come from the existing pipeline package.
//  One sub-module: core_scoreboard (cnt array, WB_PORTS decrement, query/saturation ports, clear).
// TESTING
//  T1 reset: rst pulse mid-run -> all outputs 0 next edge, FSM=RUN, cnt all 0.
//  T2 independent ALU pair, valid=11 -> issue=11; ex_valid_o=11 next cycle, contents equal.
//  T3 slot0 w_reg=5, slot1 reads r5 -> issue=01; then slot0 reads r5 -> issue=00
//     until wb_valid_i[0]=1, wb_reg_i=5; issue=01 the cycle after that.
//  T4 two MEM ops -> issue=01; without CORE_DUAL_ISSUE_EN an ALU pair -> issue=01.
//  T5 redirect_valid_i, target=0x1c000100 -> rst_jmp_o=1, target=0x1c000100 next cycle;
//     issue=00 both cycles; ex_valid_o=0; cnt cleared.
//  T6 IDLE at pc=0x1c000040 -> rst_jmp target 0x1c000044, wait_inst_o=1; int_pending_i after 10 cycles
//     -> int_detect_o pulse 1 cycle, then issue resumes.

Source files
------------

// File: rtl/core_issue_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// core_issue_ctrl_pkg
// Shared types for the backend issue controller: issue classes, the idle
// FSM encoding and the decoded-instruction layout handed over by the frontend.
// inst_t / is_t / reg_info_t follow the pipeline package field layout so the
// issue controller can be dropped in unchanged.
// ----------------------------------------------------------------------------
package core_issue_ctrl_pkg;

    typedef enum logic [2:0] {
        IC_ALU  = 3'd0,
        IC_MEM  = 3'd1,
        IC_BR   = 3'd2,
        IC_MUL  = 3'd3,
        IC_CSR  = 3'd4,
        IC_IDLE = 3'd5
    } issue_class_t;

    typedef enum logic [1:0] {
        S_RUN        = 2'd0,
        S_IDLE_FLUSH = 2'd1,
        S_IDLE_WAIT  = 2'd2,
        S_IDLE_EXIT  = 2'd3
    } idle_fsm_t;

    typedef struct packed {
        logic [2:0] iclass;
        logic [4:0] op;
    } is_t;

    typedef struct packed {
        logic [1:0][4:0] r_reg;
        logic [4:0]      w_reg;
    } reg_info_t;

    typedef struct packed {
        is_t         decode_info;
        reg_info_t   reg_info;
        logic [31:0] pc;
        logic [1:0]  bpu_predict;
        logic        fetch_excp;
    } inst_t;

    // Unused class encodings fall back to ALU (freely pairable).
    function automatic issue_class_t issue_class(input is_t d);
        issue_class_t c;
        case (d.iclass)
            3'd1:    c = IC_MEM;
            3'd2:    c = IC_BR;
            3'd3:    c = IC_MUL;
            3'd4:    c = IC_CSR;
            3'd5:    c = IC_IDLE;
            default: c = IC_ALU;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/core_issue_ctrl_if.sv
// ----------------------------------------------------------------------------
// core_issue_ctrl_if
// Frontend <-> backend issue interface.
//   inst_valid/inst : frontend two-slot decoded window (frontend drives)
//   issue           : in-order issue vector back to frontend (backend drives)
//   rst_jmp/target  : frontend flush/redirect
//   wait_inst       : idle-lock request, int_detect : idle-release pulse
// master = frontend side, slave = backend side.
// ----------------------------------------------------------------------------
interface core_issue_ctrl_if;
    import core_issue_ctrl_pkg::*;

    logic [1:0]        inst_valid;
    inst_t [1:0]       inst;
    logic [1:0]        issue;
    logic              rst_jmp;
    logic [31:0]       rst_jmp_target;
    logic              wait_inst;
    logic              int_detect;

    modport master (
        output inst_valid, inst,
        input  issue, rst_jmp, rst_jmp_target, wait_inst, int_detect
    );

    modport slave (
        input  inst_valid, inst,
        output issue, rst_jmp, rst_jmp_target, wait_inst, int_detect
    );

endinterface

// File: rtl/core_scoreboard.sv
// ----------------------------------------------------------------------------
// core_scoreboard
// Per-register outstanding-write counters for RAW hazard detection.
//   clk, rst        : clock, async active-high reset
//   i_clear         : drop all outstanding writes (backend redirect)
//   i_inc_valid/reg : issued instructions' destination registers (2 slots)
//   i_wb_valid/reg  : writeback ports retiring one write each
//   o_busy[r]       : cnt[r] != 0 (registered view, no same-cycle bypass)
//   o_sat[r]        : cnt[r] at its maximum
// r0 is never tracked.
// ----------------------------------------------------------------------------
module core_scoreboard #(
    parameter int SB_CNT_W = 2,
    parameter int WB_PORTS = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clear,
    input  logic [1:0]               i_inc_valid,
    input  logic [1:0][4:0]          i_inc_reg,
    input  logic [WB_PORTS-1:0]      i_wb_valid,
    input  logic [WB_PORTS-1:0][4:0] i_wb_reg,
    output logic [31:0]              o_busy,
    output logic [31:0]              o_sat
);

    localparam logic [SB_CNT_W-1:0] CNT_MAX = '1;

    logic [SB_CNT_W-1:0] r_cnt     [32];
    logic [SB_CNT_W-1:0] w_cnt_nxt [32];

    always_comb begin
        int v;
        v = 0;
        for (int r = 0; r < 32; r++) begin
            v = int'(r_cnt[r]);
            for (int k = 0; k < 2; k++)
                if (i_inc_valid[k] && i_inc_reg[k] == 5'(r)) v = v + 1;
            for (int p = 0; p < WB_PORTS; p++)
                if (i_wb_valid[p] && i_wb_reg[p] == 5'(r)) v = v - 1;
            // Clamp guards against a writeback for an untracked register.
            if (v < 0) v = 0;
            if (v > int'(CNT_MAX)) v = int'(CNT_MAX);
            w_cnt_nxt[r] = (r == 0 || i_clear) ? '0 : SB_CNT_W'(v);
            o_busy[r]    = (r_cnt[r] != '0);
            o_sat[r]     = (r_cnt[r] == CNT_MAX);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) r_cnt[r] <= '0;
        end else begin
            for (int r = 0; r < 32; r++) r_cnt[r] <= w_cnt_nxt[r];
        end
    end

endmodule

// File: rtl/core_issue_ctrl.sv
// ----------------------------------------------------------------------------
// core_issue_ctrl
// Backend side of the frontend/backend issue interface: in-order issue of the
// two-slot window with scoreboard RAW checks, execute-stage register, redirect
// and idle (wait_inst / int_detect) control.
// Ports:
//   clk, rst            : clock, async active-high reset
//   fe_if (slave)       : window in, issue / rst_jmp / wait_inst / int_detect out
//   i_redirect_valid    : commit-stage redirect, i_redirect_target its target
//   i_int_pending       : interrupt pending (releases idle)
//   i_wb_valid/i_wb_reg : writeback ports retiring scoreboard entries
//   i_ex_ready          : execute stage accepts new instructions
//   o_ex_valid/o_ex_inst: execute-stage register
// Build option: CORE_DUAL_ISSUE_EN enables slot1 issue; otherwise single issue.
//
// state        | meaning
// S_RUN        | normal issue
// S_IDLE_FLUSH | IDLE issued; frontend redirected to pc+4, wait_inst raised
// S_IDLE_WAIT  | holding issue until an interrupt is pending
// S_IDLE_EXIT  | int_detect pulse, then back to S_RUN
// ----------------------------------------------------------------------------
module core_issue_ctrl
    import core_issue_ctrl_pkg::*;
#(
    parameter int SB_CNT_W = 2,
    parameter int WB_PORTS = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    core_issue_ctrl_if.slave         fe_if,
    input  logic                     i_redirect_valid,
    input  logic [31:0]              i_redirect_target,
    input  logic                     i_int_pending,
    input  logic [WB_PORTS-1:0]      i_wb_valid,
    input  logic [WB_PORTS-1:0][4:0] i_wb_reg,
    input  logic                     i_ex_ready,
    output logic [1:0]               o_ex_valid,
    output inst_t [1:0]              o_ex_inst
);

    idle_fsm_t    r_state, w_state_nxt;
    logic         r_rst_jmp;
    logic [31:0]  r_rst_jmp_target;
    logic         r_idle_abort;
    logic [1:0]   r_ex_valid;
    inst_t [1:0]  r_ex_inst;

    logic [31:0]  w_busy, w_sat;
    logic [1:0]   w_issue;
    logic         w_ok0, w_idle_issue, w_wait_inst;
    issue_class_t w_cls0;
    logic [1:0][4:0] w_inc_reg;

    assign w_inc_reg = {fe_if.inst[1].reg_info.w_reg, fe_if.inst[0].reg_info.w_reg};

    core_scoreboard #(.SB_CNT_W(SB_CNT_W), .WB_PORTS(WB_PORTS)) u_sb (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (i_redirect_valid),
        .i_inc_valid (w_issue),
        .i_inc_reg   (w_inc_reg),
        .i_wb_valid  (i_wb_valid),
        .i_wb_reg    (i_wb_reg),
        .o_busy      (w_busy),
        .o_sat       (w_sat)
    );

    assign w_ok0 = !w_busy[fe_if.inst[0].reg_info.r_reg[0]] &&
                   !w_busy[fe_if.inst[0].reg_info.r_reg[1]] &&
                   !w_sat[fe_if.inst[0].reg_info.w_reg];

`ifdef CORE_DUAL_ISSUE_EN
    issue_class_t w_cls1;
    logic         w_ok1, w_dep1;

    assign w_ok1 = !w_busy[fe_if.inst[1].reg_info.r_reg[0]] &&
                   !w_busy[fe_if.inst[1].reg_info.r_reg[1]] &&
                   !w_sat[fe_if.inst[1].reg_info.w_reg];

    // Intra-window RAW/WAW against slot0's destination.
    assign w_dep1 = (fe_if.inst[0].reg_info.w_reg != 5'd0) &&
                    ((fe_if.inst[1].reg_info.r_reg[0] == fe_if.inst[0].reg_info.w_reg) ||
                     (fe_if.inst[1].reg_info.r_reg[1] == fe_if.inst[0].reg_info.w_reg) ||
                     (fe_if.inst[1].reg_info.w_reg    == fe_if.inst[0].reg_info.w_reg));
`endif

    always_comb begin
        w_cls0     = issue_class(fe_if.inst[0].decode_info);
        w_issue    = 2'b00;
        // Gated by rst so the frontend sees no issue while reset is held.
        w_issue[0] = !rst && (r_state == S_RUN) && !r_rst_jmp && !i_redirect_valid &&
                     i_ex_ready && fe_if.inst_valid[0] && w_ok0;
`ifdef CORE_DUAL_ISSUE_EN
        w_cls1     = issue_class(fe_if.inst[1].decode_info);
        w_issue[1] = w_issue[0] && fe_if.inst_valid[1] && w_ok1 && !w_dep1 &&
                     !((w_cls0 == w_cls1) && (w_cls0 != IC_ALU)) &&
                     (w_cls0 != IC_CSR) && (w_cls0 != IC_IDLE) &&
                     (w_cls1 != IC_CSR) && (w_cls1 != IC_IDLE);
`endif
        w_idle_issue = w_issue[0] && (w_cls0 == IC_IDLE);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wait_inst = 1'b0;
        unique case (r_state)
            S_RUN: begin
                if (w_idle_issue) w_state_nxt = S_IDLE_FLUSH;
            end
            S_IDLE_FLUSH: begin
                w_wait_inst = 1'b1;
                w_state_nxt = i_redirect_valid ? S_RUN : S_IDLE_WAIT;
            end
            S_IDLE_WAIT: begin
                w_wait_inst = 1'b1;
                if (i_redirect_valid)   w_state_nxt = S_RUN;
                else if (i_int_pending) w_state_nxt = S_IDLE_EXIT;
            end
            S_IDLE_EXIT: begin
                w_state_nxt = S_RUN;
            end
            default: w_state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= S_RUN;
            r_rst_jmp        <= 1'b0;
            r_rst_jmp_target <= 32'd0;
            r_idle_abort     <= 1'b0;
            r_ex_valid       <= 2'b00;
            r_ex_inst        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_rst_jmp    <= i_redirect_valid | w_idle_issue;
            // A redirect out of an idle state still releases the frontend lock.
            r_idle_abort <= i_redirect_valid &&
                            ((r_state == S_IDLE_FLUSH) || (r_state == S_IDLE_WAIT));
            if (i_redirect_valid)  r_rst_jmp_target <= i_redirect_target;
            else if (w_idle_issue) r_rst_jmp_target <= fe_if.inst[0].pc + 32'd4;
            if (i_redirect_valid)  r_ex_valid <= 2'b00;
            else if (i_ex_ready)   r_ex_valid <= w_issue;
            if (w_issue[0])        r_ex_inst  <= fe_if.inst;
        end
    end

    assign fe_if.issue          = w_issue;
    assign fe_if.rst_jmp        = r_rst_jmp;
    assign fe_if.rst_jmp_target = r_rst_jmp_target;
    assign fe_if.wait_inst      = w_wait_inst;
    assign fe_if.int_detect     = (r_state == S_IDLE_EXIT) | r_idle_abort;
    assign o_ex_valid           = r_ex_valid;
    assign o_ex_inst            = r_ex_inst;

endmodule
